axi_rd_arbiter: RTL

- Shares one downstream AXI4 read channel (AR + R) between two read masters: m0 = instruction cache, m1 = load/store unit.
- Sits between the two masters and the core's single AXI read port to the bus.
- Serialises transactions: one outstanding burst at a time, routed back to its owner.
- Grants by round-robin or fixed priority (m0 highest), selected by parameter.

---
 rtl/axi_rd_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: icache (m0) and LSU (m1) share one downstream AR/R channel.
// One burst in flight at a time; grant held from AR handshake through the rlast beat.
module axi_rd_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic [3:0]        i_m0_arid,
  input  logic [7:0]        i_m0_arlen,
  input  logic [2:0]        i_m0_arsize,
  input  logic [1:0]        i_m0_arburst,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic [3:0]        o_m0_rid,
  output logic              o_m0_rvalid,
  output logic              o_m0_rlast,
  input  logic              i_m0_rready,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic [3:0]        i_m1_arid,
  input  logic [7:0]        i_m1_arlen,
  input  logic [2:0]        i_m1_arsize,
  input  logic [1:0]        i_m1_arburst,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic [3:0]        o_m1_rid,
  output logic              o_m1_rvalid,
  output logic              o_m1_rlast,
  input  logic              i_m1_rready,
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic [3:0]        o_s_arid,
  output logic [7:0]        o_s_arlen,
  output logic [2:0]        o_s_arsize,
  output logic [1:0]        o_s_arburst,
  output logic              o_s_arvalid,
  input  logic              i_s_arready,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  input  logic [3:0]        i_s_rid,
  input  logic              i_s_rvalid,
  input  logic              i_s_rlast,
  output logic              o_s_rready,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant, last_grant_nxt;
  logic   sel_arvalid, sel_rready;

  assign sel_arvalid = grant ? i_m1_arvalid : i_m0_arvalid;
  assign sel_rready  = grant ? i_m1_rready  : i_m0_rready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (i_m0_arvalid || i_m1_arvalid) begin
          // Tie-break: m0 under fixed priority, otherwise whoever was not served last.
          if (i_m0_arvalid && i_m1_arvalid)
            grant_nxt = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
          else
            grant_nxt = i_m1_arvalid;
          last_grant_nxt = grant_nxt;
          state_nxt      = AR;
        end
      end
      AR:      if (sel_arvalid && i_s_arready) state_nxt = R;
      R:       if (i_s_rvalid && sel_rready && i_s_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_s_araddr   = '0;
    o_s_arid     = '0;
    o_s_arlen    = '0;
    o_s_arsize   = '0;
    o_s_arburst  = '0;
    o_s_arvalid  = 1'b0;
    o_m0_arready = 1'b0;
    o_m1_arready = 1'b0;
    o_s_rready   = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = '0;
    o_m0_rid     = '0;
    o_m0_rvalid  = 1'b0;
    o_m0_rlast   = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = '0;
    o_m1_rid     = '0;
    o_m1_rvalid  = 1'b0;
    o_m1_rlast   = 1'b0;
    o_busy       = (state != IDLE);
    if (state == AR) begin
      o_s_araddr   = grant ? i_m1_araddr  : i_m0_araddr;
      o_s_arid     = grant ? i_m1_arid    : i_m0_arid;
      o_s_arlen    = grant ? i_m1_arlen   : i_m0_arlen;
      o_s_arsize   = grant ? i_m1_arsize  : i_m0_arsize;
      o_s_arburst  = grant ? i_m1_arburst : i_m0_arburst;
      o_s_arvalid  = sel_arvalid;
      o_m0_arready = ~grant & i_s_arready;
      o_m1_arready = grant & i_s_arready;
    end
    if (state == R) begin
      o_s_rready = sel_rready;
      if (grant) begin
        o_m1_rdata  = i_s_rdata;
        o_m1_rresp  = i_s_rresp;
        o_m1_rid    = i_s_rid;
        o_m1_rvalid = i_s_rvalid;
        o_m1_rlast  = i_s_rlast;
      end else begin
        o_m0_rdata  = i_s_rdata;
        o_m0_rresp  = i_s_rresp;
        o_m0_rid    = i_s_rid;
        o_m0_rvalid = i_s_rvalid;
        o_m0_rlast  = i_s_rlast;
      end
    end
  end

endmodule
